bus_slave_rx: RTL and testbench

//   Downstream receiver for the valid/ready bus handshake. Accepts 3-bit beats

---
 rtl/bus_hs_pkg.sv | 9 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/bus_slave_rx.sv | 83 ++++++++
 tb/tb_bus_slave_rx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bus_hs_pkg.sv
// Shared definitions for the valid/ready bus handshake blocks.
package bus_hs_pkg;

  localparam int DATA_W        = 3;
  localparam int FRAME_LEN_DEF = 5;

  typedef logic [DATA_W-1:0] bus_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head is the raw entry at the read pointer.
module sync_fifo
  import bus_hs_pkg::*;
#(
  parameter int DATA_W = bus_hs_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bus_slave_rx.sv
// Valid/ready bus receiver: buffers beats in a FIFO, counts beats and frames,
// and flags a master that drops or changes a stalled beat.
module bus_slave_rx
  import bus_hs_pkg::*;
#(
  parameter int DATA_W    = bus_hs_pkg::DATA_W,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              frame_done,
  output logic              proto_err
);

  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_LEN - 1);

  logic                    rst_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [DATA_W-1:0]       fifo_head;
  logic                    accept;
  logic                    drain;
  logic [FC_W-1:0]         frame_cnt;
  logic                    stall_q;
  logic [DATA_W-1:0]       stall_data;

  // rst_q holds ready low for the first cycle after reset is released.
  assign ready     = !(rst || rst_q || fifo_full);
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign accept    = valid && ready;
  assign drain     = out_valid && out_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .push    (accept),
    .pop     (drain),
    .wr_data (data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      beat_cnt   <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      stall_q    <= 1'b0;
      stall_data <= '0;
      proto_err  <= 1'b0;
    end else begin
      rst_q      <= 1'b0;
      frame_done <= accept && (frame_cnt == FRAME_LAST);
      if (accept) begin
        beat_cnt  <= beat_cnt + 1'b1;
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      end
      // A stalled beat must be held unchanged by the master on the next cycle.
      stall_q    <= valid && !ready;
      stall_data <= data;
      if (stall_q && (!valid || (data != stall_data))) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_slave_rx.sv
// Directed bench for bus_slave_rx: vector table plus a counter-wrap sequence.
module tb_bus_slave_rx;
  import bus_hs_pkg::*;

  typedef struct {
    logic      rst;
    logic      valid;
    bus_word_t data;
    logic      out_ready;
    logic      exp_ready;
    logic      exp_out_valid;
    bus_word_t exp_out_data;
    logic [3:0] exp_beat_cnt;
    logic      exp_frame_done;
    logic      exp_proto_err;
  } vec_t;

  localparam int NVEC = 36;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       valid;
  bus_word_t  data;
  logic       ready;
  logic       out_valid;
  bus_word_t  out_data;
  logic       out_ready;
  logic [3:0] beat_cnt;
  logic       frame_done;
  logic       proto_err;

  int total = 0;
  int bad   = 0;
  vec_t vecs [NVEC];

  bus_slave_rx #(
    .DATA_W    (3),
    .DEPTH     (4),
    .FRAME_LEN (5),
    .CNT_W     (4)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .valid      (valid),
    .data       (data),
    .ready      (ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .beat_cnt   (beat_cnt),
    .frame_done (frame_done),
    .proto_err  (proto_err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic vec_t mk(input int r, input int v, input int d, input int o,
                              input int er, input int eov, input int eod,
                              input int ecnt, input int efd, input int epe);
    vec_t t;
    t.rst            = (r != 0);
    t.valid          = (v != 0);
    t.data           = bus_word_t'(d);
    t.out_ready      = (o != 0);
    t.exp_ready      = (er != 0);
    t.exp_out_valid  = (eov != 0);
    t.exp_out_data   = bus_word_t'(eod);
    t.exp_beat_cnt   = 4'(ecnt);
    t.exp_frame_done = (efd != 0);
    t.exp_proto_err  = (epe != 0);
    return t;
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input bus_word_t d, input logic o);
    rst       = r;
    valid     = v;
    data      = d;
    out_ready = o;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  initial begin
    // Stream, backpressure, full-with-pop, violation, reset mid-operation.
    vecs[0]  = mk(0,0,0,1, 0,0,0,0,0,0);
    vecs[1]  = mk(0,1,7,1, 1,0,0,0,0,0);
    vecs[2]  = mk(0,1,5,1, 1,1,7,1,0,0);
    vecs[3]  = mk(0,1,6,1, 1,1,5,2,0,0);
    vecs[4]  = mk(0,1,1,1, 1,1,6,3,0,0);
    vecs[5]  = mk(0,1,5,1, 1,1,1,4,0,0);
    vecs[6]  = mk(0,0,0,1, 1,1,5,5,1,0);
    vecs[7]  = mk(0,0,0,1, 1,0,0,5,0,0);
    vecs[8]  = mk(0,1,1,0, 1,0,0,5,0,0);
    vecs[9]  = mk(0,1,2,0, 1,1,1,6,0,0);
    vecs[10] = mk(0,1,3,0, 1,1,1,7,0,0);
    vecs[11] = mk(0,1,4,0, 1,1,1,8,0,0);
    vecs[12] = mk(0,1,6,0, 0,1,1,9,0,0);
    vecs[13] = mk(0,1,6,0, 0,1,1,9,0,0);
    vecs[14] = mk(0,1,6,1, 0,1,1,9,0,0);
    vecs[15] = mk(0,1,6,1, 1,1,2,9,0,0);
    vecs[16] = mk(0,1,7,1, 1,1,3,10,1,0);
    vecs[17] = mk(0,0,0,1, 1,1,4,11,0,0);
    vecs[18] = mk(0,0,0,1, 1,1,6,11,0,0);
    vecs[19] = mk(0,0,0,1, 1,1,7,11,0,0);
    vecs[20] = mk(0,0,0,1, 1,0,0,11,0,0);
    vecs[21] = mk(0,1,1,0, 1,0,0,11,0,0);
    vecs[22] = mk(0,1,2,0, 1,1,1,12,0,0);
    vecs[23] = mk(0,1,3,0, 1,1,1,13,0,0);
    vecs[24] = mk(0,1,4,0, 1,1,1,14,0,0);
    vecs[25] = mk(0,1,5,0, 0,1,1,15,1,0);
    vecs[26] = mk(0,1,6,0, 0,1,1,15,0,0);
    vecs[27] = mk(0,1,6,0, 0,1,1,15,0,1);
    vecs[28] = mk(0,0,0,0, 0,1,1,15,0,1);
    vecs[29] = mk(0,0,0,1, 0,1,1,15,0,1);
    vecs[30] = mk(0,0,0,0, 1,1,2,15,0,1);
    vecs[31] = mk(1,0,0,0, 0,1,2,15,0,1);
    vecs[32] = mk(0,0,0,0, 0,0,0,0,0,0);
    vecs[33] = mk(0,1,3,1, 1,0,0,0,0,0);
    vecs[34] = mk(0,0,0,1, 1,1,3,1,0,0);
    vecs[35] = mk(0,0,0,1, 1,0,0,1,0,0);

    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge sys_clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge sys_clk);
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].out_ready);
      #1;
      checkOutput($sformatf("v%0d.ready", i),      16'(ready),      16'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d.out_valid", i),  16'(out_valid),  16'(vecs[i].exp_out_valid));
      checkOutput($sformatf("v%0d.out_data", i),   16'(out_data),   16'(vecs[i].exp_out_data));
      checkOutput($sformatf("v%0d.beat_cnt", i),   16'(beat_cnt),   16'(vecs[i].exp_beat_cnt));
      checkOutput($sformatf("v%0d.frame_done", i), 16'(frame_done), 16'(vecs[i].exp_frame_done));
      checkOutput($sformatf("v%0d.proto_err", i),  16'(proto_err),  16'(vecs[i].exp_proto_err));
    end

    // Counter wrap: 17 back-to-back beats through a 4-bit beat counter.
    @(negedge sys_clk);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    @(negedge sys_clk);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("wrap.ready_after_rst", 16'(ready), 16'd0);
    for (int i = 0; i <= 16; i++) begin
      @(negedge sys_clk);
      applyStimulus(1'b0, 1'b1, bus_word_t'(i), 1'b1);
      #1;
      checkOutput($sformatf("wrap%0d.ready", i),      16'(ready),      16'd1);
      checkOutput($sformatf("wrap%0d.beat_cnt", i),   16'(beat_cnt),   16'(i % 16));
      checkOutput($sformatf("wrap%0d.frame_done", i), 16'(frame_done), 16'((i != 0) && (i % 5 == 0)));
      checkOutput($sformatf("wrap%0d.out_valid", i),  16'(out_valid),  16'(i > 0));
      checkOutput($sformatf("wrap%0d.out_data", i),   16'(out_data),   16'((i > 0) ? ((i - 1) % 8) : 0));
    end
    @(negedge sys_clk);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("wrap.final_cnt",   16'(beat_cnt),   16'd1);
    checkOutput("wrap.final_fd",    16'(frame_done), 16'd0);
    checkOutput("wrap.final_data",  16'(out_data),   16'd0);
    checkOutput("wrap.final_perr",  16'(proto_err),  16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
